// File: rtl/mux_pkg.sv
// rtl/mux_pkg.sv - shared defaults for the 2:1 selector
package mux_pkg;

  localparam int MUX_WIDTH_DEF = 1;
  localparam int MUX_CNT_W_DEF = 8;

endpackage

// File: rtl/mux2_cell.sv
// rtl/mux2_cell.sv - combinational 2:1 select with X-safe merge
module mux2_cell
  import mux_pkg::*;
#(
  parameter int WIDTH = MUX_WIDTH_DEF
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             select,
  output logic [WIDTH-1:0] out
);

  logic [WIDTH-1:0] sel_vec;

  assign sel_vec = {WIDTH{select}};

  // The a&b term keeps agreeing bits known when select is X; others go X.
  assign out = (a & b) | (a & ~sel_vec) | (b & sel_vec);

endmodule

// File: rtl/mux2.sv
// rtl/mux2.sv - 2:1 selector with registered result and select-change counter
module mux2
  import mux_pkg::*;
#(
  parameter int WIDTH = MUX_WIDTH_DEF,
  parameter int CNT_W = MUX_CNT_W_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             select,
  output logic [WIDTH-1:0] out,
  output logic [WIDTH-1:0] out_q,
  output logic             sel_q,
  output logic [CNT_W-1:0] sel_changes
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic changed;

  mux2_cell #(
    .WIDTH (WIDTH)
  ) u_cell (
    .a      (a),
    .b      (b),
    .select (select),
    .out    (out)
  );

  assign changed = (select != sel_q);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_q       <= '0;
      sel_q       <= 1'b0;
      sel_changes <= '0;
    end else begin
      out_q <= out;
      sel_q <= select;
      // Saturate rather than wrap so a busy select never reads as idle.
      if (changed && (sel_changes != CNT_MAX)) begin
        sel_changes <= sel_changes + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_mux2.sv
// tb/tb_mux2.sv - directed bench for mux2
module tb_mux2;

  typedef struct {
    logic a;
    logic b;
    logic sel;
    logic exp;
  } vec_t;

  logic       clk;
  logic       clk_en;
  logic       rst_n;
  logic       a;
  logic       b;
  logic       select;
  logic [7:0] a8;
  logic [7:0] b8;

  logic       out1;
  logic       out_q1;
  logic       sel_q1;
  logic [1:0] cnt1;
  logic [7:0] out8;
  logic [7:0] out_q8;
  logic       sel_q8;
  logic [7:0] cnt8;

  int checks = 0;
  int errors = 0;

  mux2 #(
    .WIDTH (1),
    .CNT_W (2)
  ) dut1 (
    .clk         (clk),
    .rst_n       (rst_n),
    .a           (a),
    .b           (b),
    .select      (select),
    .out         (out1),
    .out_q       (out_q1),
    .sel_q       (sel_q1),
    .sel_changes (cnt1)
  );

  mux2 #(
    .WIDTH (8),
    .CNT_W (8)
  ) dut8 (
    .clk         (clk),
    .rst_n       (rst_n),
    .a           (a8),
    .b           (b8),
    .select      (select),
    .out         (out8),
    .out_q       (out_q8),
    .sel_q       (sel_q8),
    .sel_changes (cnt8)
  );

  initial clk = 1'b0;
  always begin
    #5;
    if (clk_en) clk = ~clk;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t vecs[8];
    logic exp_x;

    vecs[0] = '{1'b0, 1'b0, 1'b0, 1'b0};
    vecs[1] = '{1'b0, 1'b0, 1'b1, 1'b0};
    vecs[2] = '{1'b0, 1'b1, 1'b0, 1'b0};
    vecs[3] = '{1'b0, 1'b1, 1'b1, 1'b1};
    vecs[4] = '{1'b1, 1'b0, 1'b0, 1'b1};
    vecs[5] = '{1'b1, 1'b0, 1'b1, 1'b0};
    vecs[6] = '{1'b1, 1'b1, 1'b0, 1'b1};
    vecs[7] = '{1'b1, 1'b1, 1'b1, 1'b1};

    clk_en = 1'b0;
    rst_n  = 1'b0;
    a      = 1'b0;
    b      = 1'b0;
    select = 1'b0;
    a8     = 8'h00;
    b8     = 8'h00;
    #1;
    check("rst_out_q", 32'(out_q1), 32'h0);
    check("rst_sel_q", 32'(sel_q1), 32'h0);
    check("rst_cnt", 32'(cnt1), 32'h0);
    check("rst_out_q8", 32'(out_q8), 32'h0);

    // Combinational truth table with the clock idle and reset held.
    for (int i = 0; i < 8; i++) begin
      a      = vecs[i].a;
      b      = vecs[i].b;
      select = vecs[i].sel;
      #2;
      check($sformatf("table_%0d", i), 32'(out1), 32'(vecs[i].exp));
    end

    a      = 1'b1;
    b      = 1'b0;
    select = 1'b0;
    #1 rst_n = 1'b1;
    clk_en = 1'b1;
    tick();
    check("tog_out_q_pre", 32'(out_q1), 32'h1);
    check("tog_cnt_pre", 32'(cnt1), 32'h0);
    select = 1'b1;
    #1;
    check("tog_out_now", 32'(out1), 32'h0);
    check("tog_out_q_hold", 32'(out_q1), 32'h1);
    tick();
    check("tog_out_q_post", 32'(out_q1), 32'h0);
    check("tog_cnt_post", 32'(cnt1), 32'h1);
    check("tog_sel_q", 32'(sel_q1), 32'h1);

    select = 1'b0;
    tick();
    check("pre_rst_out_q", 32'(out_q1), 32'h1);
    check("pre_rst_cnt", 32'(cnt1), 32'h2);
    #2 rst_n = 1'b0;
    #1;
    check("mid_rst_out_q", 32'(out_q1), 32'h0);
    check("mid_rst_sel_q", 32'(sel_q1), 32'h0);
    check("mid_rst_cnt", 32'(cnt1), 32'h0);
    check("mid_rst_out", 32'(out1), 32'h1);
    a = 1'b0;
    #1;
    check("mid_rst_out_follow", 32'(out1), 32'h0);

    // Saturation with a 2-bit counter.
    a      = 1'b1;
    select = 1'b0;
    #1 rst_n = 1'b1;
    for (int i = 0; i < 6; i++) begin
      select = ~select;
      tick();
      check($sformatf("sat_%0d", i), 32'(cnt1), (i < 3) ? 32'(i + 1) : 32'h3);
    end

    // Releasing reset with select high counts as one change.
    #1 rst_n = 1'b0;
    select = 1'b1;
    #1 rst_n = 1'b1;
    tick();
    check("release_sel1_cnt", 32'(cnt1), 32'h1);
    check("release_sel1_cnt8", 32'(cnt8), 32'h1);

    select = 1'b0;
    a8     = 8'hA5;
    b8     = 8'h3C;
    #1;
    check("w8_out_a", 32'(out8), 32'hA5);
    tick();
    check("w8_out_q_a", 32'(out_q8), 32'hA5);
    select = 1'b1;
    #1;
    check("w8_out_b", 32'(out8), 32'h3C);
    check("w8_out_q_hold", 32'(out_q8), 32'hA5);
    tick();
    check("w8_out_q_b", 32'(out_q8), 32'h3C);

    clk_en = 1'b0;
    select = 1'bx;
    a      = 1'b1;
    b      = 1'b1;
    #1;
    check("x_sel_agree", 32'(out1), 32'h1);
    b = 1'b0;
    #1;
    exp_x = (select === 1'b1) ? b : (select === 1'b0) ? a : 1'bx;
    check("x_sel_differ", 32'(out1), 32'(exp_x));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mux2.md
# mux2

Parameterised 2:1 selector: routes `a` or `b` to `out` under control of `select`, plus a registered copy of the result and a select-activity counter. Used as a generic datapath steering primitive wherever a one-of-two choice is needed. The combinational path serves same-cycle consumers. The registered path serves timing-critical consumers.

## Interface
Parameters:
- `WIDTH`, default 1: data width of `a`, `b`, `out` and `out_q`.
- `CNT_W`, default 8: width of the select-change counter.

Ports:
- `clk`  in  1  single clock; all state updates on the rising edge.
- `rst_n`  in  1  reset, asynchronous and active-low; assertion immediately clears all registers.
- `a`  in  WIDTH  data input, chosen when `select`=0.
- `b`  in  WIDTH  data input, chosen when `select`=1.
- `select`  in  1  steering control.
- `out`  out  WIDTH  combinational result.
- `out_q`  out  WIDTH  registered result.
- `sel_q`  out  1  registered `select`.
- `sel_changes`  out  CNT_W  saturating count of `select` transitions since reset.

## Operation
- `out` = `select` ? `b` : `a`. Purely combinational, with no clock dependency.
  - Valid with `clk` idle and `rst_n` in any state.
- If `select` is X/Z, `out` must not silently pick a side in simulation.
  - Per bit where `a`==`b`, `out` = `a`.
  - Elsewhere, `out` = X.
- `out_q` captures `out` on each rising `clk` edge while `rst_n`=1.
- `sel_q` captures `select` on each rising `clk` edge while `rst_n`=1.
- `sel_changes` increments by 1 on a clock edge where `select` differs from `sel_q`.
  - Saturates at 2^CNT_W−1 and holds there.
  - No wrap-around.
- Reset values: `out_q` = 0, `sel_q` = 0, `sel_changes` = 0.
  - `out` is unaffected by reset.
- Reset mid-operation:
  - Registers clear asynchronously.
  - The first edge after `rst_n` rises compares `select` against `sel_q`=0.
  - Therefore `select`=1 at release counts as one change.

## Timing
- `out`: zero-cycle latency, combinational from `a`, `b`, `select`.
- `out_q`, `sel_q`: one-cycle latency; reflect inputs sampled at the previous rising edge.
- `sel_changes`: updates one edge after the transition is sampled.
- Simultaneous change of `select` and data: `out` reflects the new pair; `out_q` registers whatever is stable at the edge.
- No handshake; inputs must meet setup and hold to `clk` for the registered outputs only.
- `rst_n` deassertion must be synchronised externally to `clk`.

## Structure
- Package `mux_pkg`: default constants `MUX_WIDTH_DEF`=1 and `MUX_CNT_W_DEF`=8.
- Sub-module `mux2_cell`:
  - Contains the combinational select logic and the X-safe merge.
  - Instantiated once; `out` is driven directly from it.
- Top level holds the three registers and the saturating counter.

## Test plan
- All 8 combinations of `a`,`b`,`select` (WIDTH=1), 2 time units apart, `clk` idle.
  - `out` = 0,0,0,1,1,0,1,1 in order (a,b,sel = 000,001,010,011,100,101,110,111).
- `a`=1, `b`=0, then toggle `select` 0→1 with `clk` running.
  - `out` falls immediately.
  - `out_q` falls one edge later.
  - `sel_changes` = 1.
- `select`=X with `a`=`b`=1 → `out`=1.
  - With `a`=1, `b`=0 → `out`=X.
- CNT_W=2, toggle `select` every cycle for 6 cycles → `sel_changes` = 1, 2, 3, 3, 3, 3.
- With `out_q`=1 and `sel_changes`=2, assert `rst_n`=0 between edges.
  - All registers read 0 at once.
  - `out` still follows its inputs.
- WIDTH=8, `a`=8'hA5, `b`=8'h3C.
  - `select` 0 → `out`=8'hA5; `select` 1 → `out`=8'h3C.
  - `out_q` follows one cycle later.
